cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 28 ++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the instruction sequencer (master) and the datapath / memory side (slave).
interface cpu_sequencer_if;
    logic [3:0] opcode;
    logic       mem_ack;
    logic       ir_load;
    logic       pc_inc;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       load_enable;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
    logic       illegal;
    logic       mem_timeout;
    logic [7:0] retired;

    modport master (
        input  opcode, mem_ack,
        output ir_load, pc_inc, alu_op, reg_write, load_enable,
               mem_req, mem_we, halted, illegal, mem_timeout, retired
    );

    modport slave (
        output opcode, mem_ack,
        input  ir_load, pc_inc, alu_op, reg_write, load_enable,
               mem_req, mem_we, halted, illegal, mem_timeout, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer with a bounded data-memory wait.
// Optional feature macro SEQ_SINGLE_STEP_EN adds the step input and the STEP_WAIT state.
//
// state     | meaning
// FETCH     | pulse ir_load, capture next instruction
// DECODE    | classify opcode, pick next state
// EXEC      | ALU writeback, retire
// MEM       | hold mem_req until mem_ack or MEM_TIMEOUT waits elapse
// HALT      | parked until reset
// STEP_WAIT | idle until step (single-step builds only)
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    cpu_sequencer_if.master bus
);

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_STEP_WAIT} state_t;
    localparam state_t S_IDLE = S_STEP_WAIT;
`else
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
    localparam state_t S_IDLE = S_FETCH;
`endif

    localparam logic [3:0] TMO = 4'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic       r_is_store;
    logic [7:0] r_retired;
    logic       r_illegal;

    logic w_is_alu, w_is_load, w_is_store, w_is_halt, w_is_mem, w_illegal;
    logic w_ir_load, w_pc_inc, w_reg_write, w_load_enable, w_mem_req, w_mem_we;
    logic w_timeout, w_retire, w_halted;

    assign w_is_alu   = ~bus.opcode[3];
    assign w_is_load  = (bus.opcode == 4'b1000);
    assign w_is_store = (bus.opcode == 4'b1001);
    assign w_is_halt  = (bus.opcode == 4'b1111);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_illegal  = bus.opcode[3] & ~w_is_mem & ~w_is_halt;

    always_comb begin
        w_next        = r_state;
        w_ir_load     = 1'b0;
        w_pc_inc      = 1'b0;
        w_reg_write   = 1'b0;
        w_load_enable = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_timeout     = 1'b0;
        w_retire      = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_load = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_alu)       w_next = S_EXEC;
                else if (w_is_mem)  w_next = S_MEM;
                else if (w_is_halt) w_next = S_HALT;
                else                w_next = S_IDLE;
            end
            S_EXEC: begin
                w_reg_write = 1'b1;
                w_pc_inc    = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_IDLE;
            end
            S_MEM: begin
                // The request is withdrawn in the extra cycle after the last permitted wait.
                if (r_wait != TMO) begin
                    w_mem_req = 1'b1;
                    w_mem_we  = r_is_store;
                end
                if (bus.mem_ack) begin
                    w_pc_inc      = 1'b1;
                    w_retire      = 1'b1;
                    w_reg_write   = ~r_is_store;
                    w_load_enable = ~r_is_store;
                    w_next        = S_IDLE;
                end else if (r_wait == TMO) begin
                    w_timeout = 1'b1;
                    w_pc_inc  = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step) w_next = S_FETCH;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait     <= 4'd0;
            r_is_store <= 1'b0;
            r_retired  <= 8'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_next;
            // Illegal opcodes are flagged from a register so no enable follows opcode combinationally.
            r_illegal <= (r_state == S_DECODE) & w_illegal;
            if (r_state == S_DECODE) begin
                r_wait     <= 4'd0;
                r_is_store <= w_is_store;
            end else if (r_state == S_MEM && r_wait != TMO) begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_retire) r_retired <= r_retired + 8'd1;
        end
    end

    assign bus.ir_load     = w_ir_load & ~reset;
    assign bus.pc_inc      = (w_pc_inc | r_illegal) & ~reset;
    assign bus.reg_write   = w_reg_write & ~reset;
    assign bus.load_enable = w_load_enable & ~reset;
    assign bus.mem_req     = w_mem_req & ~reset;
    assign bus.mem_we      = w_mem_we & ~reset;
    assign bus.mem_timeout = w_timeout & ~reset;
    assign bus.illegal     = r_illegal & ~reset;
    assign bus.halted      = w_halted & ~reset;
    assign bus.retired     = r_retired;
`ifdef SEQ_SINGLE_STEP_EN
    assign bus.alu_op = (bus.opcode[3] || r_state == S_STEP_WAIT) ? 3'd0 : bus.opcode[2:0];
`else
    assign bus.alu_op = bus.opcode[3] ? 3'd0 : bus.opcode[2:0];
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Cycle-accurate scoreboard bench for cpu_sequencer; SEQ_SINGLE_STEP_EN selects the single-step scenario.
module tb_cpu_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_in = 1'b0;
`endif

    cpu_sequencer_if bus();

    cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_SINGLE_STEP_EN
        .step  (step_in),
`endif
        .bus   (bus)
    );

    localparam logic [8:0] IR = 9'h100;
    localparam logic [8:0] PC = 9'h080;
    localparam logic [8:0] RW = 9'h040;
    localparam logic [8:0] LE = 9'h020;
    localparam logic [8:0] MR = 9'h010;
    localparam logic [8:0] MW = 9'h008;
    localparam logic [8:0] HL = 9'h004;
    localparam logic [8:0] IL = 9'h002;
    localparam logic [8:0] TO = 9'h001;

    typedef struct {
        string       tag;
        logic [19:0] vec;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_ret  = 8'd0;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ctl=%h alu=%h ret=%0d, expected ctl=%h alu=%h ret=%0d",
                     tag, got[19:11], got[10:8], got[7:0], exp[19:11], exp[10:8], exp[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, {bus.ir_load, bus.pc_inc, bus.reg_write, bus.load_enable, bus.mem_req,
                          bus.mem_we, bus.halted, bus.illegal, bus.mem_timeout, bus.alu_op,
                          bus.retired}, e.vec);
        end
    end

    task automatic step(input string tag, input logic rst, input logic [3:0] opc, input logic ack,
                        input logic stp, input logic [8:0] ctl, input bit chk);
        logic [2:0] a;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.opcode  = opc;
        bus.mem_ack = ack;
`ifdef SEQ_SINGLE_STEP_EN
        step_in = stp;
`else
        if (stp) a = 3'd0;
`endif
        a = opc[3] ? 3'd0 : opc[2:0];
        if (chk) sb.push_back('{tag, {ctl, a, exp_ret}});
    endtask

    task automatic reset_seq();
        step("rst0", 1'b1, 4'd0, 1'b0, 1'b0, 9'd0, 1'b0);
        exp_ret = 8'd0;
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    task automatic alu(input string tag, input logic [3:0] opc, input logic ack, input logic [8:0] extra);
        step({tag, "_f"}, 1'b0, opc, ack, 1'b0, IR | extra, 1'b1);
        step({tag, "_d"}, 1'b0, opc, ack, 1'b0, 9'd0, 1'b1);
        step({tag, "_e"}, 1'b0, opc, ack, 1'b0, RW | PC, 1'b1);
        exp_ret++;
    endtask

    // ack_cycle: MEM cycle index carrying mem_ack (15 is the cycle after the last request), -1 for none
    task automatic memop(input string tag, input logic [3:0] opc, input int ack_cycle);
        bit         st;
        bit         done;
        logic [8:0] rq;
        st   = (opc == 4'b1001);
        rq   = st ? (MR | MW) : MR;
        done = 1'b0;
        step({tag, "_f"}, 1'b0, opc, 1'b0, 1'b0, IR, 1'b1);
        step({tag, "_d"}, 1'b0, opc, 1'b0, 1'b0, 9'd0, 1'b1);
        for (int i = 0; i <= 15; i++) begin
            if (!done) begin
                if (i == ack_cycle) begin
                    step({tag, "_ack"}, 1'b0, opc, 1'b1, 1'b0,
                         ((i < 15) ? rq : 9'd0) | PC | (st ? 9'd0 : (RW | LE)), 1'b1);
                    exp_ret++;
                    done = 1'b1;
                end else if (i < 15) begin
                    step({tag, "_wait"}, 1'b0, opc, 1'b0, 1'b0, rq, 1'b1);
                end else begin
                    step({tag, "_tmo"}, 1'b0, opc, 1'b0, 1'b0, TO | PC, 1'b1);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bus.opcode  = 4'd0;
        bus.mem_ack = 1'b0;
        reset_seq();
`ifdef SEQ_SINGLE_STEP_EN
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 4'd0, 1'b0, 1'b0, 9'd0, 1'b1);
        step("step_pulse", 1'b0, 4'd0, 1'b0, 1'b1, 9'd0, 1'b1);
        alu("stepped", 4'b0010, 1'b0, 9'd0);
        for (int i = 0; i < 5; i++) step("idle2", 1'b0, 4'd0, 1'b0, 1'b0, 9'd0, 1'b1);
`else
        alu("alu010", 4'b0010, 1'b0, 9'd0);
        alu("alu_ackign", 4'b0111, 1'b1, 9'd0);
        memop("load2", 4'b1000, 2);
        memop("store_tmo", 4'b1001, -1);
        memop("store_last", 4'b1001, 14);
        memop("store_edge", 4'b1001, 15);
        memop("load0", 4'b1000, 0);
        step("mr_f", 1'b0, 4'b1000, 1'b0, 1'b0, IR, 1'b1);
        step("mr_d", 1'b0, 4'b1000, 1'b0, 1'b0, 9'd0, 1'b1);
        step("mr_m", 1'b0, 4'b1000, 1'b0, 1'b0, MR, 1'b1);
        step("mr_rst", 1'b1, 4'd0, 1'b0, 1'b0, 9'd0, 1'b1);
        exp_ret = 8'd0;
        step("ill_f", 1'b0, 4'b1100, 1'b0, 1'b0, IR, 1'b1);
        step("ill_d", 1'b0, 4'b1100, 1'b0, 1'b0, 9'd0, 1'b1);
        alu("after_ill", 4'b0001, 1'b0, PC | IL);
        for (int i = 1; i < 256; i++) alu("wrap", 4'(i % 8), 1'b0, 9'd0);
        step("halt_f", 1'b0, 4'b1111, 1'b0, 1'b0, IR, 1'b1);
        step("halt_d", 1'b0, 4'b1111, 1'b0, 1'b0, 9'd0, 1'b1);
        for (int i = 0; i < 22; i++) step("halted", 1'b0, 4'b1111, 1'(i % 2), 1'b0, HL, 1'b1);
        reset_seq();
        alu("post_halt", 4'b0101, 1'b0, 9'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", 20'(sb.size()), 20'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
